// File: rtl/bridge_rx.sv
// bridge_rx: turns the ASCII "R<addr>" / "W<addr><data>" command stream from the
// UART receiver into single-cycle register-bus requests at the head of the core chain.
module bridge_rx (
  input  logic        clk,
  input  logic        rst,
  input  logic [7:0]  data_i,
  input  logic        valid_i,
  output logic [15:0] addr_o,
  output logic [15:0] wdata_o,
  output logic [15:0] rdata_o,
  output logic        rw_o,
  output logic        valid_o
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_READ  = 2'd1;
  localparam logic [1:0] S_WRITE = 2'd2;

  logic [1:0]  state;
  logic [3:0]  count;
  logic [31:0] buffer;

  logic       is_hex;
  logic       is_term;
  logic       is_r;
  logic       is_w;
  logic [3:0] nibble;
  logic [3:0] limit;

  // Command letters are accepted in either case, matching the hex digits.
  always_comb begin
    is_hex  = 1'b0;
    nibble  = data_i[3:0];
    is_term = (data_i == 8'h0D) || (data_i == 8'h0A);
    is_r    = (data_i == 8'h52) || (data_i == 8'h72);
    is_w    = (data_i == 8'h57) || (data_i == 8'h77);
    if (data_i >= 8'h30 && data_i <= 8'h39) begin
      is_hex = 1'b1;
    end else if ((data_i >= 8'h41 && data_i <= 8'h46) ||
                 (data_i >= 8'h61 && data_i <= 8'h66)) begin
      is_hex = 1'b1;
      nibble = data_i[3:0] + 4'd9;
    end
    limit = (state == S_WRITE) ? 4'd8 : 4'd4;
  end

  assign rdata_o = 16'h0000;

  // The low 16 bits of the shift buffer always hold the last four nibbles,
  // so a read takes its address there and a write splits the full 32 bits.
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= S_IDLE;
      count   <= 4'd0;
      buffer  <= 32'h0;
      addr_o  <= 16'h0;
      wdata_o <= 16'h0;
      rw_o    <= 1'b0;
      valid_o <= 1'b0;
    end else begin
      valid_o <= 1'b0;
      if (valid_i) begin
        if (is_r) begin
          state <= S_READ;
          count <= 4'd0;
        end else if (is_w) begin
          state <= S_WRITE;
          count <= 4'd0;
        end else begin
          case (state)
            S_READ, S_WRITE: begin
              if (is_hex) begin
                if (count < limit) begin
                  buffer <= {buffer[27:0], nibble};
                  count  <= count + 4'd1;
                end else begin
                  state <= S_IDLE;
                end
              end else if (is_term) begin
                if (count == limit) begin
                  valid_o <= 1'b1;
                  if (state == S_WRITE) begin
                    addr_o  <= buffer[31:16];
                    wdata_o <= buffer[15:0];
                    rw_o    <= 1'b1;
                  end else begin
                    addr_o <= buffer[15:0];
                    rw_o   <= 1'b0;
                  end
                end
                state <= S_IDLE;
              end else begin
                state <= S_IDLE;
              end
            end
            default: state <= S_IDLE;
          endcase
        end
      end
    end
  end

endmodule

// File: tb/tb_bridge_rx.sv
// Testbench for bridge_rx: directed messages plus random traffic, checked every
// cycle against a message-level model that collects digits in a queue.
module tb_bridge_rx;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [7:0]  data_i = 8'h00;
  logic        valid_i = 1'b0;
  logic [15:0] addr_o;
  logic [15:0] wdata_o;
  logic [15:0] rdata_o;
  logic        rw_o;
  logic        valid_o;

  int errors = 0;
  int checks = 0;
  int dutPulses = 0;
  int modelPulses = 0;

  // Model state: message kind (0 none, 1 read, 2 write) and collected digit values.
  int          mType = 0;
  int          digits[$];
  logic        expValid = 1'b0;
  logic [15:0] expAddr = 16'h0;
  logic [15:0] expWdata = 16'h0;
  logic        expRw = 1'b0;
  logic [31:0] mVal;

  bridge_rx dut (
    .clk(clk), .rst(rst), .data_i(data_i), .valid_i(valid_i),
    .addr_o(addr_o), .wdata_o(wdata_o), .rdata_o(rdata_o),
    .rw_o(rw_o), .valid_o(valid_o)
  );

  always #5 clk = ~clk;

  function automatic int hexVal(input logic [7:0] c);
    if (c >= 8'h30 && c <= 8'h39) return int'(c) - 48;
    if (c >= 8'h41 && c <= 8'h46) return int'(c) - 55;
    if (c >= 8'h61 && c <= 8'h66) return int'(c) - 87;
    return -1;
  endfunction

  // Message-level reference: what each accepted byte means for the message so far.
  always @(posedge clk) begin
    if (rst) begin
      mType = 0;
      digits.delete();
      expValid = 1'b0;
      expAddr = 16'h0;
      expWdata = 16'h0;
      expRw = 1'b0;
    end else begin
      expValid = 1'b0;
      if (valid_i) begin
        if (data_i == "R" || data_i == "r") begin
          mType = 1;
          digits.delete();
        end else if (data_i == "W" || data_i == "w") begin
          mType = 2;
          digits.delete();
        end else if (mType != 0) begin
          if (hexVal(data_i) >= 0) begin
            if (digits.size() < 4 * mType) digits.push_back(hexVal(data_i));
            else mType = 0;
          end else if (data_i == 8'h0D || data_i == 8'h0A) begin
            if (digits.size() == 4 * mType) begin
              mVal = 0;
              foreach (digits[i]) mVal = mVal * 16 + 32'(digits[i]);
              if (mType == 1) begin
                expAddr = mVal[15:0];
                expRw = 1'b0;
              end else begin
                expAddr = mVal[31:16];
                expWdata = mVal[15:0];
                expRw = 1'b1;
              end
              expValid = 1'b1;
              modelPulses++;
            end
            mType = 0;
          end else begin
            mType = 0;
          end
        end
      end
    end
  end

  // Every cycle, all outputs must equal the model's view.
  always @(negedge clk) begin
    checks++;
    if (valid_o !== expValid || addr_o !== expAddr || wdata_o !== expWdata ||
        rw_o !== expRw || rdata_o !== 16'h0) begin
      errors++;
      $display("[TB] FAIL cycle t=%0t: got v=%b a=%h w=%h rd=%h rw=%b, expected v=%b a=%h w=%h rd=0000 rw=%b",
               $time, valid_o, addr_o, wdata_o, rdata_o, rw_o, expValid, expAddr, expWdata, expRw);
    end
    if (valid_o === 1'b1) dutPulses++;
  end

  task automatic sendByte(input logic [7:0] b);
    @(negedge clk);
    data_i = b;
    valid_i = 1'b1;
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clk);
      valid_i = 1'b0;
      data_i = 8'($urandom);
    end
  endtask

  task automatic applyStimulus(input string s, input int gapPct);
    for (int i = 0; i < s.len(); i++) begin
      if ($urandom_range(99) < gapPct) idle(1);
      sendByte(s[i]);
    end
    idle(3);
  endtask

  task automatic checkOutput(input string name, input int pulses, input logic [15:0] a,
                             input logic [15:0] w, input logic rw);
    checks++;
    if (dutPulses != pulses || modelPulses != pulses || addr_o !== a || wdata_o !== w || rw_o !== rw) begin
      errors++;
      $display("[TB] FAIL %s: got pulses=%0d model=%0d a=%h w=%h rw=%b, expected pulses=%0d a=%h w=%h rw=%b",
               name, dutPulses, modelPulses, addr_o, wdata_o, rw_o, pulses, a, w, rw);
    end
  endtask

  task automatic randomHex(input int n);
    string hx = "0123456789abcdefABCDEF";
    for (int i = 0; i < n; i++) begin
      if ($urandom_range(3) == 0) idle(1);
      sendByte(hx[$urandom_range(21)]);
    end
  endtask

  initial begin
    idle(2);
    rst = 1'b0;
    idle(2);
    checkOutput("reset", 0, 16'h0, 16'h0, 1'b0);

    applyStimulus("R0004\015\012", 0);
    checkOutput("read", 1, 16'h0004, 16'h0000, 1'b0);
    applyStimulus("W0005001F\015", 0);
    checkOutput("write1", 2, 16'h0005, 16'h001F, 1'b1);
    applyStimulus("w00ffBEEF\012", 0);
    checkOutput("write2", 3, 16'h00FF, 16'hBEEF, 1'b1);

    applyStimulus("R00G1\015", 0);
    applyStimulus("R001\015", 0);
    applyStimulus("R00012\015", 0);
    checkOutput("malformed", 3, 16'h00FF, 16'hBEEF, 1'b1);
    applyStimulus("R0001\015", 0);
    checkOutput("recover", 4, 16'h0001, 16'hBEEF, 1'b0);

    applyStimulus("R12W00010002\015", 0);
    checkOutput("resync", 5, 16'h0001, 16'h0002, 1'b1);

    applyStimulus("W0003", 0);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    checkOutput("midreset", 5, 16'h0, 16'h0, 1'b0);
    applyStimulus("00AA\015", 0);
    checkOutput("after_reset", 5, 16'h0, 16'h0, 1'b0);
    applyStimulus("R0003\015", 0);
    checkOutput("read_after_reset", 6, 16'h0003, 16'h0000, 1'b0);

    applyStimulus("R0002\015W00070055\015", 0);
    checkOutput("throughput", 8, 16'h0007, 16'h0055, 1'b1);

    // Random traffic: good and broken messages, random case, gaps and resets.
    for (int n = 0; n < 400; n++) begin
      int kind = $urandom_range(5);
      if (kind <= 1) begin
        sendByte($urandom_range(1) ? "R" : "r");
        randomHex(4);
      end else if (kind <= 3) begin
        sendByte($urandom_range(1) ? "W" : "w");
        randomHex(8);
      end else if (kind == 4) begin
        for (int k = 0; k < $urandom_range(1, 6); k++) sendByte(8'($urandom));
      end else begin
        sendByte($urandom_range(1) ? "R" : "W");
        randomHex($urandom_range(0, 10));
      end
      sendByte($urandom_range(1) ? 8'h0D : 8'h0A);
      if ($urandom_range(29) == 0) begin
        @(negedge clk);
        valid_i = 1'b0;
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
      end
      if ($urandom_range(1) == 0) idle($urandom_range(1, 3));
    end
    idle(4);
    checks++;
    if (dutPulses != modelPulses) begin
      errors++;
      $display("[TB] FAIL pulse_total: got %0d, expected %0d", dutPulses, modelPulses);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/bridge_rx.md
# bridge_rx

Parses the ASCII command stream from the UART receiver into register-bus transactions. It is the head of the daisy-chained core bus: its outputs feed the first core's `addr_i`/`wdata_i`/`rdata_i`/`rw_i`/`valid_i`. Each well-formed read or write message produces exactly one single-cycle bus request. Malformed input is dropped silently.

## Interface
Parameters:
- None. Address and data widths are fixed at 16 bits.

Ports:
- `clk`  input  1  system clock; all logic on rising edge.
- `rst`  input  1  synchronous, active-high reset.
- `data_i`  input  8  received byte from the UART receiver.
- `valid_i`  input  1  `data_i` is valid this cycle; one byte per asserted cycle.
- `addr_o`  output  16  bus address.
- `wdata_o`  output  16  bus write data.
- `rdata_o`  output  16  bus read data. Constant 0; downstream cores fill it in.
- `rw_o`  output  1  1 = write, 0 = read.
- `valid_o`  output  1  single-cycle bus request strobe.

## Operation
- Read message: `R`, then 4 hex digits (address), then terminator.
- Write message: `W`, then 4 hex digits (address), then 4 hex digits (data), then terminator.
- Terminator is CR (0x0D) or LF (0x0A).
- Hex digits: `0`–`9`, `A`–`F`, `a`–`f`. Most significant nibble arrives first.
- Bytes with `valid_i` = 0 are ignored. Back-to-back bytes on consecutive cycles are supported with no stall.
- States:
  - IDLE: `R` → READ, nibble count cleared. `W` → WRITE, count cleared. Any other byte, including a stray LF after CR, → stays IDLE.
  - READ:
    - Hex digit while count < 4 → shift nibble into the buffer, count+1.
    - Terminator with count == 4 → issue read, → IDLE.
  - WRITE:
    - Hex digit while count < 8 → shift nibble into the buffer, count+1.
    - Terminator with count == 8 → issue write, → IDLE.
- Resync: `R` or `W` received in READ or WRITE restarts parsing as a new message of that type. Partial data is discarded.
- Error: in READ or WRITE, any of the following → IDLE, no request:
  - a non-hex, non-terminator byte;
  - an early terminator;
  - an excess hex digit (5th for a read, 9th for a write).
- Issue:
  - `addr_o` = buffered address; for a write, `wdata_o` = buffered data.
  - A read leaves `wdata_o` unchanged.
  - `rw_o` = message type.
  - `valid_o` = 1 for exactly one cycle.
- `addr_o`, `wdata_o` and `rw_o` hold their values between requests. They change only at issue.
- The parse buffer is internal; outputs never show partial messages.

## Timing
- Reset values: `addr_o` = 0, `wdata_o` = 0, `rdata_o` = 0, `rw_o` = 0, `valid_o` = 0, state IDLE, count = 0.
- Latency: `valid_o` rises in the cycle after the clock edge that samples the terminator byte. It falls one cycle later.
- A new message may begin on the byte directly after a terminator. Minimum spacing between requests:
  - 6 accepted bytes for reads;
  - 10 accepted bytes for writes.
- `rst` asserted mid-message aborts it: next cycle the state is IDLE and all outputs are at reset values. A pulse due that cycle is suppressed.
- No backpressure: downstream must accept `valid_o` unconditionally. The core bus is a pipeline, so this holds.

## Test plan
- Read: bytes "R0004\r\n" → one `valid_o` pulse, `addr_o` = 0x0004, `rw_o` = 0, `wdata_o` = 0. The trailing LF produces no second pulse.
- Write, mixed case: "W0005001F\r" then "w00ffBEEF\n" → two pulses:
  - first: `addr_o` = 0x0005, `wdata_o` = 0x001F, `rw_o` = 1;
  - second: `addr_o` = 0x00FF, `wdata_o` = 0xBEEF.
- Malformed input, then recovery:
  - "R00G1\r", "R001\r" and "R00012\r" → no pulse;
  - "R0001\r" sent next → pulse with `addr_o` = 0x0001.
- Resync: "R12W00010002\r" → a single write pulse, `addr_o` = 0x0001, `wdata_o` = 0x0002. No read pulse.
- Reset mid-message: send "W0003", pulse `rst` for 1 cycle, then send "00AA\r" → no pulse and outputs stay 0. A following "R0003\r" → read pulse with `addr_o` = 0x0003.
- Throughput: "R0002\r" and "W00070055\r" on consecutive cycles with `valid_i` held high, followed by idle gaps with `valid_i` low → two pulses at the correct cycles with correct fields.
